// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   Test-pattern colour generator that sits behind a VGA sync generator.
//   The sync timing and pixel coordinates go through a two-stage pipeline.
//   Stage 1 registers the inputs and runs the colour-bar counters. Stage 2
//   registers the colour, which is computed from the stage-1 values, so every
//   o_ timing signal leaves exactly two clocks after its i_ counterpart and
//   lines up with the colour of the same pixel.
//   The active pattern and the frame counter change only on a frame boundary,
//   which is the rising edge of i_vblank. Visible pixels therefore never see
//   a pattern change partway through a frame.
//
// Ports
//   i_clk, i_rst_n        pixel clock / asynchronous active-low reset
//   i_hsync .. i_display_on  timing from the sync generator
//   i_hpos, i_vpos        current pixel coordinates (COORD_W bits)
//   i_pattern             requested pattern, latched at the frame boundary
//   o_hsync .. o_display_on  timing delayed by two clocks
//   o_red, o_grn, o_blu   3-bit colour channels, zero outside the display area
//   o_frame_cnt           count of completed frames, wraps 255 -> 0
module vga_pattern_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int BAR_WIDTH   = 80,
  parameter int COORD_W     = 10,
  parameter int CHECK_SHIFT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_hsync,
  input  logic               i_hblank,
  input  logic               i_vsync,
  input  logic               i_vblank,
  input  logic               i_display_on,
  input  logic [COORD_W-1:0] i_hpos,
  input  logic [COORD_W-1:0] i_vpos,
  input  logic [2:0]         i_pattern,
  output logic               o_hsync,
  output logic               o_hblank,
  output logic               o_vsync,
  output logic               o_vblank,
  output logic               o_display_on,
  output logic [2:0]         o_red,
  output logic [2:0]         o_grn,
  output logic [2:0]         o_blu,
  output logic [7:0]         o_frame_cnt
);

  typedef enum logic [2:0] {
    PAT_BLACK = 3'd0,
    PAT_WHITE = 3'd1,
    PAT_BARS  = 3'd2,
    PAT_CHECK = 3'd3,
    PAT_MBAR  = 3'd4,
    PAT_GRAD  = 3'd5
  } pattern_e;

  typedef struct packed {
    logic hsync;
    logic hblank;
    logic vsync;
    logic vblank;
    logic display_on;
  } timing_t;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb_t;

  localparam logic [COORD_W-1:0] H_VIS_C  = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] BAR_LAST = COORD_W'(BAR_WIDTH - 1);
  // The moving bar compares hpos[COORD_W-1:4] with the frame counter. Both
  // sides are cut down to the narrower of the two widths.
  localparam int MB_W = (COORD_W - 4 < 8) ? COORD_W - 4 : 8;

  // Stage 1
  timing_t            s1_tim_q;
  logic [COORD_W-1:0] s1_hpos_q, s1_vpos_q;
  logic [COORD_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [2:0]         bar_q, bar_d;
  // Control state
  logic               vblank_prev_q;
  pattern_e           pattern_q;
  logic [7:0]         frame_cnt_q;
  // Stage 2 (outputs)
  timing_t            s2_tim_q;
  rgb_t               rgb_q, rgb_d;

  logic frame_start;
  assign frame_start = i_vblank & ~vblank_prev_q;

  // Colour-bar index, kept without a divider. pix_cnt/bar refer to the pixel
  // that is entering stage 1. The sync generator steps hpos by one on every
  // clock, so counting clocks from hpos == 0 tracks the pixel position.
  always_comb begin
    // NOTE: every always_comb output gets a default first; otherwise a path
    // that leaves it unassigned would infer a latch.
    pix_cnt_d = pix_cnt_q;
    bar_d     = bar_q;
    if (i_hpos == '0) begin
      pix_cnt_d = '0;
      bar_d     = '0;
    end else if (i_hpos < H_VIS_C) begin
      if (pix_cnt_q == BAR_LAST) begin
        pix_cnt_d = '0;
        if (bar_q != 3'd7) bar_d = bar_q + 3'd1;  // saturate at the last bar
      end else begin
        pix_cnt_d = pix_cnt_q + COORD_W'(1);
      end
    end
  end

  // Colour for the pixel held in stage 1.
  always_comb begin
    rgb_d = '0;
    unique case (pattern_q)
      PAT_WHITE: rgb_d = '{r: 3'd7, g: 3'd7, b: 3'd7};
      // The bar order white, yellow, cyan, green, magenta, red, blue, black
      // reduces to one inverted index bit per channel.
      PAT_BARS:  rgb_d = '{r: {3{~bar_q[1]}}, g: {3{~bar_q[2]}}, b: {3{~bar_q[0]}}};
      PAT_CHECK: if (s1_hpos_q[CHECK_SHIFT] ^ s1_vpos_q[CHECK_SHIFT])
                   rgb_d = '{r: 3'd7, g: 3'd7, b: 3'd7};
      PAT_MBAR:  if (s1_hpos_q[4 +: MB_W] == frame_cnt_q[MB_W-1:0])
                   rgb_d = '{r: 3'd7, g: 3'd7, b: 3'd7};
                 else
                   rgb_d = '{r: 3'd0, g: 3'd0, b: 3'd7};
      PAT_GRAD:  rgb_d = '{r: s1_hpos_q[5:3], g: s1_vpos_q[5:3], b: frame_cnt_q[7:5]};
      default:   rgb_d = '0;
    endcase
    if (!s1_tim_q.display_on) rgb_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_tim_q      <= '0;
      s1_hpos_q     <= '0;
      s1_vpos_q     <= '0;
      pix_cnt_q     <= '0;
      bar_q         <= '0;
      vblank_prev_q <= 1'b0;
      pattern_q     <= PAT_BLACK;
      frame_cnt_q   <= '0;
      s2_tim_q      <= '0;
      rgb_q         <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every register
      // then samples its pre-edge value, which keeps the stages in lockstep.
      s1_tim_q      <= '{hsync: i_hsync, hblank: i_hblank, vsync: i_vsync,
                         vblank: i_vblank, display_on: i_display_on};
      s1_hpos_q     <= i_hpos;
      s1_vpos_q     <= i_vpos;
      pix_cnt_q     <= pix_cnt_d;
      bar_q         <= bar_d;
      vblank_prev_q <= i_vblank;
      if (frame_start) begin
        pattern_q   <= pattern_e'(i_pattern);
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
      s2_tim_q      <= s1_tim_q;
      rgb_q         <= rgb_d;
    end
  end

  // Each pattern reads only a few coordinate bits. This sink keeps the
  // remaining bits of the stage-1 coordinates from being reported as unused.
  logic unused_coord;
  assign unused_coord = ^{s1_hpos_q, s1_vpos_q};

  assign o_hsync      = s2_tim_q.hsync;
  assign o_hblank     = s2_tim_q.hblank;
  assign o_vsync      = s2_tim_q.vsync;
  assign o_vblank     = s2_tim_q.vblank;
  assign o_display_on = s2_tim_q.display_on;
  assign o_red        = rgb_q.r;
  assign o_grn        = rgb_q.g;
  assign o_blu        = rgb_q.b;
  assign o_frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen
//   Directed bench for vga_pattern_gen. It uses a 16-pixel visible line and a
//   bar width of 2. It drives a small raster of 20 x 6 clocks per frame with
//   4 visible lines. Inputs change on the falling edge and outputs are
//   sampled on the following falling edge. Each step compares the outputs
//   with the bench's own prediction for the pixel driven one step earlier.
//   The scenario tasks add hand-computed pixel checks.
module tb_vga_pattern_gen;

  localparam int H_VIS = 16;
  localparam int H_TOT = 20;
  localparam int V_VIS = 4;
  localparam int V_TOT = 6;
  localparam int BAR_W = 2;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       i_hsync = 1'b0, i_hblank = 1'b0, i_vsync = 1'b0, i_vblank = 1'b0;
  logic       i_display_on = 1'b0;
  logic [9:0] i_hpos = '0, i_vpos = '0;
  logic [2:0] i_pattern = '0;
  logic       o_hsync, o_hblank, o_vsync, o_vblank, o_display_on;
  logic [2:0] o_red, o_grn, o_blu;
  logic [7:0] o_frame_cnt;

  always #5 i_clk = ~i_clk;

  vga_pattern_gen #(
    .H_VISIBLE(H_VIS), .BAR_WIDTH(BAR_W), .COORD_W(10), .CHECK_SHIFT(1)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_hsync(i_hsync), .i_hblank(i_hblank), .i_vsync(i_vsync),
    .i_vblank(i_vblank), .i_display_on(i_display_on),
    .i_hpos(i_hpos), .i_vpos(i_vpos), .i_pattern(i_pattern),
    .o_hsync(o_hsync), .o_hblank(o_hblank), .o_vsync(o_vsync),
    .o_vblank(o_vblank), .o_display_on(o_display_on),
    .o_red(o_red), .o_grn(o_grn), .o_blu(o_blu), .o_frame_cnt(o_frame_cnt)
  );

  typedef struct packed {
    logic       hs, hb, vs, vb, de;
    logic [8:0] rgb;
  } obs_t;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cur_h = 0, cur_v = 0;     // next pixel to drive
  int         prev_h = -1, prev_v = -1; // pixel whose result is in stage 2
  int         out_h = -1, out_v = -1;   // pixel shown on the outputs now
  logic       tb_prev_vb = 1'b0;
  logic [7:0] exp_frame = '0;
  logic [2:0] exp_pat = '0;
  obs_t       prev_exp = '0;

  // white, yellow, cyan, green, magenta, red, blue, black as {r,g,b} octal
  logic [8:0] bar_tbl [8] = '{9'o777, 9'o770, 9'o077, 9'o070,
                              9'o707, 9'o700, 9'o007, 9'o000};

  function automatic logic [8:0] model_rgb(int h, int v, logic [2:0] p,
                                           logic [7:0] fc, logic de);
    int b;
    if (!de) return 9'o000;
    case (p)
      3'd1: return 9'o777;
      3'd2: begin
        b = h / BAR_W;
        if (b > 7) b = 7;
        return bar_tbl[b];
      end
      3'd3: return (((h >> 1) ^ (v >> 1)) & 1) != 0 ? 9'o777 : 9'o000;
      3'd4: return ((h >> 4) & 63) == (int'(fc) & 63) ? 9'o777 : 9'o007;
      3'd5: return 9'(((h >> 3) & 7) << 6 | ((v >> 3) & 7) << 3 | (int'(fc) >> 5));
      default: return 9'o000;
    endcase
  endfunction

  // Drive one pixel, clock it, and compare the outputs with the prediction
  // for the previously driven pixel.
  task automatic step();
    obs_t e;
    logic [21:0] act, exp_v;
    i_hpos       = 10'(cur_h);
    i_vpos       = 10'(cur_v);
    i_hblank     = (cur_h >= H_VIS);
    i_hsync      = (cur_h >= 17 && cur_h <= 18);
    i_vblank     = (cur_v >= V_VIS);
    i_vsync      = (cur_v == 5);
    i_display_on = !i_hblank && !i_vblank;
    if (i_rst_n) begin
      if (i_vblank && !tb_prev_vb) begin
        exp_frame = exp_frame + 8'd1;
        exp_pat   = i_pattern;
      end
      tb_prev_vb = i_vblank;
    end
    e = '{hs: i_hsync, hb: i_hblank, vs: i_vsync, vb: i_vblank, de: i_display_on,
          rgb: model_rgb(cur_h, cur_v, exp_pat, exp_frame, i_display_on)};
    @(posedge i_clk);
    @(negedge i_clk);
    if (!i_rst_n) begin
      tb_prev_vb = 1'b0;
      exp_frame  = '0;
      exp_pat    = '0;
      prev_exp   = '0;
      e          = '0;
      prev_h     = -1;
      prev_v     = -1;
    end
    act   = {o_hsync, o_hblank, o_vsync, o_vblank, o_display_on,
             o_red, o_grn, o_blu, o_frame_cnt};
    exp_v = {prev_exp, exp_frame};
    n_checks++;
    if (act !== exp_v)
      $display("FAIL pipeline pixel(%0d,%0d) t=%0t: got %h expected %h",
               prev_h, prev_v, $time, act, exp_v);
    else
      n_pass++;
    out_h    = prev_h;
    out_v    = prev_v;
    prev_exp = e;
    prev_h   = i_rst_n ? cur_h : -1;
    prev_v   = i_rst_n ? cur_v : -1;
    cur_h = cur_h + 1;
    if (cur_h == H_TOT) begin
      cur_h = 0;
      cur_v = (cur_v + 1) % V_TOT;
    end
  endtask

  // Step until pixel (h,v) is on the outputs, then compare its colour.
  task automatic check_pixel(string name, int h, int v, logic [8:0] exp_rgb);
    bit found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step();
      if (out_h == h && out_v == v) found = 1;
    end
    n_checks++;
    if (!found)
      $display("FAIL %s: pixel (%0d,%0d) never reached the outputs", name, h, v);
    else if ({o_red, o_grn, o_blu} !== exp_rgb)
      $display("FAIL %s: rgb got %o expected %o", name, {o_red, o_grn, o_blu}, exp_rgb);
    else
      n_pass++;
  endtask

  // Run until the next drive is pixel (0,0). The vblank edge has then passed.
  task automatic run_to_frame_start();
    step();
    for (int i = 0; i < 200 && !(cur_h == 0 && cur_v == 0); i++) step();
  endtask

  task automatic test_reset();
    i_pattern = 3'd1;
    #1 i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_hsync, o_hblank, o_vsync, o_vblank, o_display_on, o_red, o_grn, o_blu,
         o_frame_cnt} !== 22'h0)
      $display("FAIL reset_outputs: got %h expected 0",
               {o_hsync, o_hblank, o_vsync, o_vblank, o_display_on,
                o_red, o_grn, o_blu, o_frame_cnt});
    else
      n_pass++;
    @(negedge i_clk);
    for (int i = 0; i < 4; i++) step();
    i_rst_n = 1'b1;
  endtask

  task automatic test_latency();
    i_pattern = 3'd1;
    run_to_frame_start();
    check_pixel("lat_white", 3, 1, 9'o777);
    check_pixel("lat_hblank", 17, 1, 9'o000);
    n_checks++;
    if ({o_hblank, o_hsync, o_display_on} !== 3'b110)
      $display("FAIL lat_hblank_timing: got %b expected 110", {o_hblank, o_hsync, o_display_on});
    else
      n_pass++;
  endtask

  task automatic test_bars();
    int         px [10] = '{0, 1, 2, 3, 4, 5, 12, 14, 15, 2};
    int         py [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic [8:0] ex [10] = '{9'o777, 9'o777, 9'o770, 9'o770, 9'o077, 9'o077,
                            9'o007, 9'o000, 9'o000, 9'o770};
    i_pattern = 3'd2;
    run_to_frame_start();
    for (int i = 0; i < 10; i++)
      check_pixel($sformatf("bars_%0d_%0d", px[i], py[i]), px[i], py[i], ex[i]);
  endtask

  task automatic test_checker();
    i_pattern = 3'd3;
    run_to_frame_start();
    check_pixel("chk_0_0", 0, 0, 9'o000);
    check_pixel("chk_2_0", 2, 0, 9'o777);
    check_pixel("chk_0_2", 0, 2, 9'o777);
    check_pixel("chk_2_2", 2, 2, 9'o000);
  endtask

  task automatic test_pattern_latch();
    i_pattern = 3'd0;
    run_to_frame_start();
    check_pixel("latch_pre", 2, 1, 9'o000);
    i_pattern = 3'd1;  // mid-frame request: must wait for the next vblank edge
    check_pixel("latch_same_line", 8, 1, 9'o000);
    check_pixel("latch_same_frame", 10, 3, 9'o000);
    run_to_frame_start();
    check_pixel("latch_next_frame", 0, 0, 9'o777);
    // Change the pattern in the same cycle as the vblank edge, then change it
    // again straight afterwards. Only the first value is latched.
    for (int i = 0; i < 200 && !(cur_v == V_VIS && cur_h == 0); i++) step();
    i_pattern = 3'd2;
    step();
    i_pattern = 3'd1;
    run_to_frame_start();
    check_pixel("latch_at_boundary", 2, 0, 9'o770);
  endtask

  task automatic test_moving_bar();
    i_pattern = 3'd4;
    run_to_frame_start();
    // frame count is small and non-zero here, so hpos[9:4]=0 does not match
    check_pixel("mbar_blue", 3, 0, 9'o007);
  endtask

  task automatic test_frame_wrap();
    bit seen = 0;
    i_pattern = 3'd5;
    for (int i = 0; i < 260 * H_TOT * V_TOT && !seen; i++) begin
      step();
      if (o_frame_cnt == 8'd255) seen = 1;
    end
    n_checks++;
    if (!seen) $display("FAIL wrap_reach_255: frame counter never reached 255");
    else n_pass++;
    check_pixel("grad_fc255", 8, 1, 9'o107);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step();
      if (o_frame_cnt != 8'd255) seen = 1;
    end
    n_checks++;
    if (o_frame_cnt !== 8'd0)
      $display("FAIL wrap_to_0: frame_cnt got %0d expected 0", o_frame_cnt);
    else
      n_pass++;
    check_pixel("grad_fc0", 8, 1, 9'o100);
  endtask

  task automatic test_async_reset();
    i_pattern = 3'd1;
    run_to_frame_start();
    check_pixel("arst_pre_white", 6, 1, 9'o777);
    #2 i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_hsync, o_hblank, o_vsync, o_vblank, o_display_on, o_red, o_grn, o_blu,
         o_frame_cnt} !== 22'h0)
      $display("FAIL arst_immediate: got %h expected 0",
               {o_hsync, o_hblank, o_vsync, o_vblank, o_display_on,
                o_red, o_grn, o_blu, o_frame_cnt});
    else
      n_pass++;
    @(negedge i_clk);
    for (int i = 0; i < 3; i++) step();
    i_rst_n = 1'b1;
    check_pixel("arst_black", 10, 2, 9'o000);
    run_to_frame_start();
    n_checks++;
    if (o_frame_cnt !== 8'd1)
      $display("FAIL arst_frame_cnt: got %0d expected 1", o_frame_cnt);
    else
      n_pass++;
    check_pixel("arst_white_after_edge", 0, 0, 9'o777);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bars();
    test_checker();
    test_pattern_latch();
    test_moving_bar();
    test_frame_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640: visible pixels per line.
REQ-002 Parameter BAR_WIDTH, default 80: pixels per colour bar.
REQ-003 Parameter COORD_W, default 10: width of i_hpos and i_vpos.
REQ-004 Parameter CHECK_SHIFT, default 4: checker cell size is 2^CHECK_SHIFT pixels.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 i_clk  in  1: pixel clock, rising-edge active.
REQ-007 i_rst_n  in  1: asynchronous active-low reset.
REQ-008 i_hsync, i_hblank, i_vsync, i_vblank, i_display_on  in  1 each: timing inputs from the sync generator.
REQ-009 i_hpos, i_vpos  in  COORD_W: current pixel coordinates from the sync generator.
REQ-010 i_pattern  in  3: requested pattern, sampled only at frame boundary.
REQ-011 o_hsync, o_hblank, o_vsync, o_vblank, o_display_on  out  1 each: timing inputs delayed to align with colour.
REQ-012 o_red, o_grn, o_blu  out  3 each: pixel colour.
REQ-013 o_frame_cnt  out  8: completed-frame counter.

Function
REQ-014 The pipeline SHALL be exactly 2 cycles: every o_ timing signal equals its i_ counterpart 2 rising edges earlier, with no gaps.
REQ-015 The colour output for a pixel SHALL appear in the same cycle as that pixel's delayed o_display_on.
REQ-016 When delayed o_display_on=0, o_red, o_grn and o_blu SHALL all be 0, whatever the pattern.
REQ-017 Frame boundary = cycle in which i_vblank=1 and i_vblank was 0 in the previous cycle (rising edge, detected with a registered copy).
REQ-018 On a frame boundary, the block SHALL latch i_pattern into the active-pattern register.
REQ-019 On a frame boundary, o_frame_cnt SHALL increment by 1 and wrap 255->0.
REQ-020 The active pattern SHALL be stable for the whole visible frame; changes of i_pattern at any other time SHALL have no effect.
REQ-021 Pattern 0: black (0,0,0).
REQ-022 Pattern 1: white (7,7,7).
REQ-023 Pattern 2, colour bars: bar index b = min(floor(hpos/BAR_WIDTH), 7).
REQ-024 Pattern 2 colours SHALL be, for b=0..7: white, yellow, cyan, green, magenta, red, blue, black.
REQ-025 Pattern 2 components SHALL be full scale: each channel is 7 or 0.
REQ-026 Pattern 2 SHALL compute b with a pixel counter and a bar counter, not a divider.
REQ-027 Pattern 2 counters SHALL clear when i_hpos=0 and advance on every clock while i_hpos < H_VISIBLE.
REQ-028 The bar index SHALL saturate at 7.
REQ-029 Pattern 3, checkerboard: white if hpos[CHECK_SHIFT] XOR vpos[CHECK_SHIFT] = 1, else black.
REQ-030 Pattern 4, moving bar: white when hpos[COORD_W-1:4] equals o_frame_cnt, with both sides truncated to the narrower width; else blue (0,0,7).
REQ-031 Pattern 5, gradient: red = hpos[5:3], grn = vpos[5:3], blu = o_frame_cnt[7:5].
REQ-032 Patterns 6 and 7 SHALL output black.
REQ-033 If a frame boundary and an i_pattern change occur in the same cycle, the new i_pattern value SHALL be latched.
REQ-034 hpos/vpos used by a pattern SHALL be the values sampled in the same pipeline beat as that pixel's i_display_on, with no skew.

Reset
REQ-035 While i_rst_n=0, all outputs, pipeline registers, active pattern, frame counter, bar counters and the previous-vblank register SHALL be 0.
REQ-036 Reset assertion SHALL take effect immediately, without waiting for a clock edge.
REQ-037 Reset release SHALL be acted on at the first rising edge with i_rst_n=1.
REQ-038 Reset mid-frame SHALL restart with pattern 0 until the next frame boundary.
REQ-039 The first rising edge of i_vblank after reset SHALL count as a frame boundary.

Verification
REQ-040 Latency: H_VISIBLE=16, BAR_WIDTH=2, pattern 1 -> each o_ timing signal equals its input delayed by 2 cycles; with o_display_on=1, colour is (7,7,7); otherwise (0,0,0).
REQ-041 Colour bars: pattern 2, same parameters -> pixels 0-1 (7,7,7); 2-3 (7,7,0); 4-5 (0,7,7); 14-15 (0,0,0).
REQ-042 Pattern latch timing: set i_pattern 0->1 mid-frame -> output stays black until after the next i_vblank rising edge, then white on the next visible pixel.
REQ-043 Frame counter wrap: run 256 frames -> o_frame_cnt goes 255->0; pattern 5 blu channel follows o_frame_cnt[7:5].
REQ-044 Async reset: assert i_rst_n=0 mid-line -> all outputs 0 with no clock edge; after release, pattern 0 (black) until the first vblank edge, then o_frame_cnt=1.
REQ-045 Checkerboard: pattern 3, CHECK_SHIFT=1 -> (hpos,vpos)=(0,0) black, (2,0) white, (2,2) black.
